mod_execute_mc: RTL and testbench

MOD_EXECUTE_MC -- requirements
Module: mod_execute_mc

---
 rtl/mod_execute_mc.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_mod_execute_mc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_execute_mc.sv
// Multi-cycle integer execute unit: single-cycle ALU/shift/move ops and a
// WIDTH-step signed shift-add IMUL, all results held in registered outputs.
`timescale 1ns/1ps
module mod_execute_mc #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [63:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic [63:0]      out_pc,
  output logic             out_wb_en,
  output logic             out_flags_we,
  output logic             out_cf,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_pf,
  output logic             out_illegal
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_IMUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state_q, state_d;

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   ext_q, ext_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [63:0]        pc_q, pc_d;
  logic               wb_q, wb_d;
  logic               fwe_q, fwe_d;
  logic               cf_q, cf_d;
  logic               zf_q, zf_d;
  logic               sf_q, sf_d;
  logic               of_q, of_d;
  logic               pf_q, pf_d;
  logic               ill_q, ill_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]    cnt_q, cnt_d;

  // {zf, sf, pf} of a result; PF looks at the low byte only
  function automatic logic [2:0] zsp(input logic [WIDTH-1:0] r);
    return {r == '0, r[WIDTH-1], ~^r[7:0]};
  endfunction

  logic accept;
  logic is_imul;
  assign accept  = in_valid && in_ready && !flush;
  assign is_imul = (in_op == OP_IMUL);

  logic [SH_W-1:0] sh_cnt;
  logic [WIDTH:0]  add_full, sub_full, shl_full, shr_full, sar_full;
  assign sh_cnt   = in_b[SH_W-1:0];
  assign add_full = {1'b0, in_a} + {1'b0, in_b};
  assign sub_full = {1'b0, in_a} - {1'b0, in_b};
  // One guard bit beside the operand catches the last bit shifted out
  assign shl_full = {1'b0, in_a} << sh_cnt;
  assign shr_full = {in_a, 1'b0} >> sh_cnt;
  assign sar_full = $signed({in_a, 1'b0}) >>> sh_cnt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_of, alu_wb, alu_fwe, alu_ill;
  logic [2:0]       alu_zsp;

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_wb  = 1'b1;
    alu_fwe = 1'b1;
    alu_ill = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_cf  = add_full[WIDTH];
        alu_of  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_cf  = sub_full[WIDTH];
        alu_of  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_full[WIDTH-1] != in_a[WIDTH-1]);
        alu_wb  = (in_op != OP_CMP);
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_SHL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_cf  = shl_full[WIDTH];
        alu_fwe = (sh_cnt != '0);
      end
      OP_SHR: begin
        alu_res = shr_full[WIDTH:1];
        alu_cf  = shr_full[0];
        alu_fwe = (sh_cnt != '0);
      end
      OP_SAR: begin
        alu_res = sar_full[WIDTH:1];
        alu_cf  = sar_full[0];
        alu_fwe = (sh_cnt != '0);
      end
      OP_MOV: begin
        alu_res = in_b;
        alu_fwe = 1'b0;
      end
      OP_IMUL: begin
        alu_res = '0;
      end
      default: begin
        alu_ill = 1'b1;
        alu_wb  = 1'b0;
        alu_fwe = 1'b0;
      end
    endcase
  end

  assign alu_zsp = zsp(alu_res);

  // Shift-add step: the multiplier MSB carries negative weight, so it subtracts
  logic [2*WIDTH-1:0] addend, acc_step;
  logic               last_step;
  logic [WIDTH-1:0]   prod_lo, prod_hi;
  logic               mul_ovf;
  logic [2:0]         mul_zsp;

  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign last_step = (cnt_q == SH_W'(WIDTH - 1));
  assign acc_step  = last_step ? (acc_q - addend) : (acc_q + addend);
  assign prod_lo   = acc_step[WIDTH-1:0];
  assign prod_hi   = acc_step[2*WIDTH-1:WIDTH];
  assign mul_ovf   = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
  assign mul_zsp   = zsp(prod_lo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = is_imul ? S_BUSY : S_DONE;
        S_BUSY: if (last_step) state_d = S_DONE;
        S_DONE: begin
          if (accept)         state_d = is_imul ? S_BUSY : S_DONE;
          else if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    ext_d    = ext_q;
    tag_d    = tag_q;
    pc_d     = pc_q;
    wb_d     = wb_q;
    fwe_d    = fwe_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    pf_d     = pf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      tag_d = in_tag;
      pc_d  = in_pc;
      if (is_imul) begin
        valid_d  = 1'b0;
        mcand_d  = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        mplier_d = in_b;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        valid_d  = 1'b1;
        result_d = alu_res;
        ext_d    = '0;
        wb_d     = alu_wb;
        fwe_d    = alu_fwe;
        cf_d     = alu_cf;
        of_d     = alu_of;
        ill_d    = alu_ill;
        {zf_d, sf_d, pf_d} = alu_zsp;
      end
    end else if (state_q == S_BUSY) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SH_W'(1);
      if (last_step) begin
        valid_d  = 1'b1;
        result_d = prod_lo;
        ext_d    = prod_hi;
        wb_d     = 1'b1;
        fwe_d    = 1'b1;
        cf_d     = mul_ovf;
        of_d     = mul_ovf;
        ill_d    = 1'b0;
        {zf_d, sf_d, pf_d} = mul_zsp;
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ext_q    <= '0;
      tag_q    <= '0;
      pc_q     <= '0;
      wb_q     <= 1'b0;
      fwe_q    <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      pf_q     <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      ext_q    <= ext_d;
      tag_q    <= tag_d;
      pc_q     <= pc_d;
      wb_q     <= wb_d;
      fwe_q    <= fwe_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
      pf_q     <= pf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_result   = result_q;
  assign out_ext      = ext_q;
  assign out_tag      = tag_q;
  assign out_pc       = pc_q;
  assign out_wb_en    = wb_q;
  assign out_flags_we = fwe_q;
  assign out_cf       = cf_q;
  assign out_zf       = zf_q;
  assign out_sf       = sf_q;
  assign out_of       = of_q;
  assign out_pf       = pf_q;
  assign out_illegal  = ill_q;

endmodule

// File: tb/tb_mod_execute_mc.sv
// Directed bench for mod_execute_mc at WIDTH=8: hand-computed results, flags,
// IMUL latency, backpressure, and reset/flush interrupting an IMUL.
`timescale 1ns/1ps
module tb_mod_execute_mc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a, in_b, out_result, out_ext;
  logic [3:0]   in_tag, out_tag;
  logic [63:0]  in_pc, out_pc;
  logic         out_wb_en, out_flags_we, out_cf, out_zf, out_sf, out_of, out_pf, out_illegal;
  logic [4:0]   flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign flags = {out_cf, out_zf, out_sf, out_of, out_pf};

  mod_execute_mc #(.WIDTH(W), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ext(out_ext), .out_tag(out_tag), .out_pc(out_pc),
    .out_wb_en(out_wb_en), .out_flags_we(out_flags_we),
    .out_cf(out_cf), .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .out_pf(out_pf),
    .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, input logic [63:0] pc);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_pc    = pc;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input logic [63:0] pc);
    offer(op, a, b, tag, pc);
    tick();
    in_valid = 1'b0;
  endtask

  // flags argument is {cf, zf, sf, of, pf}
  task automatic chk_out(input string name, input logic [7:0] res, input logic [7:0] ext,
                         input logic [4:0] fl, input logic wb, input logic fwe, input logic ill);
    $display("[TB] %s: result=%02h ext=%02h flags=%05b wb=%0d fwe=%0d ill=%0d", name,
             out_result, out_ext, flags, out_wb_en, out_flags_we, out_illegal);
    chk({name, ".valid"},  64'(out_valid),    64'd1);
    chk({name, ".result"}, 64'(out_result),   64'(res));
    chk({name, ".ext"},    64'(out_ext),      64'(ext));
    chk({name, ".flags"},  64'(flags),        64'(fl));
    chk({name, ".wb_en"},  64'(out_wb_en),    64'(wb));
    chk({name, ".flags_we"}, 64'(out_flags_we), 64'(fwe));
    chk({name, ".illegal"},  64'(out_illegal),  64'(ill));
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0; in_pc = '0;
    repeat (2) tick();
    chk("rst.valid",  64'(out_valid),  64'd0);
    chk("rst.result", 64'(out_result), 64'd0);
    chk("rst.ext",    64'(out_ext),    64'd0);
    chk("rst.tag",    64'(out_tag),    64'd0);
    chk("rst.pc",     out_pc,          64'd0);
    chk("rst.flags",  64'(flags),      64'd0);
    chk("rst.ctl",    64'({out_wb_en, out_flags_we, out_illegal}), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);

    run_op(4'd0, 8'hFF, 8'h01, 4'd5, 64'h1000);
    chk_out("add", 8'h00, 8'h00, 5'b11001, 1'b1, 1'b1, 1'b0);
    chk("add.tag", 64'(out_tag), 64'd5);
    chk("add.pc",  out_pc,       64'h1000);
    tick();
    chk("add.drain", 64'(out_valid), 64'd0);

    run_op(4'd1, 8'h80, 8'h01, 4'd1, 64'h1004);
    chk_out("sub", 8'h7F, 8'h00, 5'b00010, 1'b1, 1'b1, 1'b0);
    tick();
    run_op(4'd2, 8'h05, 8'h07, 4'd1, 64'h1008);
    chk_out("cmp", 8'hFE, 8'h00, 5'b10100, 1'b0, 1'b1, 1'b0);
    tick();

    // back-to-back ops with out_ready held high
    offer(4'd3, 8'hF0, 8'h3C, 4'd1, 64'h100C);
    tick();
    chk_out("and", 8'h30, 8'h00, 5'b00001, 1'b1, 1'b1, 1'b0);
    chk("and.in_ready", 64'(in_ready), 64'd1);
    offer(4'd5, 8'hFF, 8'h0F, 4'd2, 64'h1010);
    tick();
    in_valid = 1'b0;
    chk_out("xor", 8'hF0, 8'h00, 5'b00101, 1'b1, 1'b1, 1'b0);
    chk("xor.tag", 64'(out_tag), 64'd2);
    tick();

    run_op(4'd6, 8'h81, 8'h09, 4'd0, 64'h0);
    chk_out("shl", 8'h02, 8'h00, 5'b10000, 1'b1, 1'b1, 1'b0);
    tick();
    run_op(4'd7, 8'h81, 8'h03, 4'd0, 64'h0);
    chk_out("shr", 8'h10, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0);
    tick();
    run_op(4'd8, 8'h86, 8'h02, 4'd0, 64'h0);
    chk_out("sar", 8'hE1, 8'h00, 5'b10101, 1'b1, 1'b1, 1'b0);
    tick();
    run_op(4'd6, 8'h55, 8'h08, 4'd0, 64'h0);
    chk_out("shl0", 8'h55, 8'h00, 5'b00001, 1'b1, 1'b0, 1'b0);
    tick();
    run_op(4'd9, 8'h12, 8'h00, 4'd0, 64'h0);
    chk_out("mov", 8'h00, 8'h00, 5'b01001, 1'b1, 1'b0, 1'b0);
    tick();
    run_op(4'd12, 8'h12, 8'h34, 4'd0, 64'h0);
    chk_out("illegal", 8'h00, 8'h00, 5'b01001, 1'b0, 1'b0, 1'b1);
    tick();

    // IMUL: edge 1 accepts, result on edge 9
    run_op(4'd10, 8'hFF, 8'h03, 4'd7, 64'h2000);
    chk("imul.e1_valid", 64'(out_valid), 64'd0);
    chk("imul.e1_ready", 64'(in_ready),  64'd0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("imul.busy_valid", 64'(out_valid), 64'd0);
      chk("imul.busy_ready", 64'(in_ready),  64'd0);
    end
    tick();
    chk_out("imul", 8'hFD, 8'hFF, 5'b00100, 1'b1, 1'b1, 1'b0);
    chk("imul.tag", 64'(out_tag), 64'd7);
    chk("imul.pc",  out_pc,       64'h2000);
    tick();

    run_op(4'd10, 8'h10, 8'h10, 4'd8, 64'h2004);
    repeat (7) tick();
    chk("imul2.e8_valid", 64'(out_valid), 64'd0);
    tick();
    chk_out("imul2", 8'h00, 8'h01, 5'b11011, 1'b1, 1'b1, 1'b0);
    tick();

    // backpressure: held result, pending op not taken until out_ready
    out_ready = 1'b0;
    run_op(4'd0, 8'h10, 8'h20, 4'd3, 64'h3000);
    chk_out("bp.add", 8'h30, 8'h00, 5'b00001, 1'b1, 1'b1, 1'b0);
    offer(4'd1, 8'h09, 8'h01, 4'd4, 64'h4000);
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp.valid",  64'(out_valid),  64'd1);
      chk("bp.result", 64'(out_result), 64'h30);
      chk("bp.tag",    64'(out_tag),    64'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.sub", 8'h08, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0);
    chk("bp.sub_tag", 64'(out_tag), 64'd4);
    tick();
    chk("bp.drain", 64'(out_valid), 64'd0);

    // reset in the middle of an IMUL
    run_op(4'd10, 8'h05, 8'h03, 4'd1, 64'h0);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_imul.valid", 64'(out_valid), 64'd0);
    chk("rst_imul.ready", 64'(in_ready),  64'd1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_imul.no_valid", 64'(out_valid), 64'd0);
    end
    run_op(4'd0, 8'h03, 8'h04, 4'd2, 64'h5000);
    chk_out("rst_imul.add", 8'h07, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b0);
    tick();

    // flush in the middle of an IMUL, with a competing op offered
    run_op(4'd10, 8'h05, 8'h03, 4'd1, 64'h0);
    repeat (2) tick();
    flush = 1'b1;
    offer(4'd0, 8'h01, 8'h01, 4'd9, 64'h0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.valid", 64'(out_valid), 64'd0);
    chk("flush.ready", 64'(in_ready),  64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("flush.no_valid", 64'(out_valid), 64'd0);
    end
    run_op(4'd0, 8'h7F, 8'h01, 4'd6, 64'h6000);
    chk_out("flush.add", 8'h80, 8'h00, 5'b00110, 1'b1, 1'b1, 1'b0);
    chk("flush.add_tag", 64'(out_tag), 64'd6);
    tick();

    // flush drops a held result
    out_ready = 1'b0;
    run_op(4'd4, 8'h01, 8'h02, 4'd3, 64'h0);
    chk_out("hold.or", 8'h03, 8'h00, 5'b00001, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("hold.flush_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
